// File: rtl/trace_read_pkg.sv
// trace_read_pkg: shared types and helpers for the trace read sequencer
package trace_read_pkg;
    localparam int NUM_SRC   = 5;
    localparam int SEL_W     = 3;
    localparam int TAG_IDX_W = 16;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    typedef struct packed {
        logic [SEL_W-1:0]     ch;
        logic [TAG_IDX_W-1:0] idx;
        logic                 last;
    } beat_tag_t;

    function automatic logic [SEL_W-1:0] lowest_src(input logic [NUM_SRC-1:0] m);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (m[i]) r = SEL_W'(i);
        return r;
    endfunction
endpackage

// File: rtl/trace_read_seq_fifo.sv
// sample_skid_fifo: 2-entry register FIFO with occupancy count
module sample_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         valid,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wr_ptr, rd_ptr;
    logic [1:0]   count_q;

    assign rd_data = mem[rd_ptr];
    assign valid   = count_q != 2'd0;
    assign count   = count_q;

    // storage, pointers and occupancy; writer guarantees no overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_en) rd_ptr <= ~rd_ptr;
            count_q <= count_q + {1'b0, wr_en} - {1'b0, rd_en};
        end
    end
endmodule

// File: rtl/trace_read_seq.sv
// trace_read_seq: walks enabled sources, reads BRAM, streams captured samples
module trace_read_seq
    import trace_read_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 640
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4:0]        ch_mask,
    output logic              busy,
    output logic              done,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [2:0]        sel,
    input  logic [WIDTH-1:0]  mux_y,
    output logic [WIDTH-1:0]  m_data,
    output logic [2:0]        m_ch,
    output logic [ADDR_W-1:0] m_idx,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready
);
    localparam int FW = WIDTH + $bits(beat_tag_t);

    state_t               state_q, state_d;
    logic [NUM_SRC-1:0]   mask_q, above;
    logic [SEL_W-1:0]     ch_q, sel_q;
    logic [ADDR_W-1:0]    addr_q, idx_q;
    logic                 last_q, infl_q, zero_done_q;
    logic                 accept, pop, issue, last_addr, final_read;
    logic [1:0]           count;
    logic [2:0]           pend;
    beat_tag_t            wr_tag, rd_tag;
    logic [FW-1:0]        fifo_out;
    logic [TAG_IDX_W-1:0] unused_idx;

    assign accept     = state_q == IDLE && start;
    assign above      = mask_q & ({NUM_SRC{1'b1}} << ch_q << 1);
    assign pop        = m_valid & m_ready;
    assign pend       = {1'b0, count} + {2'b0, infl_q};
    assign issue      = state_q == READ && pend < 3'd2 + {2'b0, pop};
    assign last_addr  = addr_q == ADDR_W'(DEPTH - 1);
    assign final_read = issue && last_addr && above == '0;
    assign busy       = state_q != IDLE;
    assign bram_en    = issue;
    assign bram_addr  = addr_q;
    assign sel        = sel_q;
    assign wr_tag     = '{sel_q, TAG_IDX_W'(idx_q), last_q};
    assign {m_data, rd_tag} = fifo_out;
    assign m_ch       = rd_tag.ch;
    assign m_idx      = rd_tag.idx[ADDR_W-1:0];
    assign m_last     = rd_tag.last;
    assign unused_idx = rd_tag.idx;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next state; frame done fires once the pipeline and buffer are empty
    always_comb begin
        state_d = state_q;
        done    = zero_done_q;
        if (accept && ch_mask != '0) state_d = READ;
        if (final_read) state_d = DRAIN;
        if (state_q == DRAIN && !infl_q && count == 2'd0) begin
            state_d = IDLE;
            done    = 1'b1;
        end
    end

    // address/channel walk and the one-cycle tag delay matching BRAM latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q      <= '0;
            ch_q        <= '0;
            addr_q      <= '0;
            sel_q       <= '0;
            idx_q       <= '0;
            last_q      <= 1'b0;
            infl_q      <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            zero_done_q <= accept && ch_mask == '0;
            infl_q      <= issue;
            if (accept && ch_mask != '0) begin
                mask_q <= ch_mask;
                ch_q   <= lowest_src(ch_mask);
                addr_q <= '0;
            end
            if (issue) begin
                sel_q  <= ch_q;
                idx_q  <= addr_q;
                last_q <= final_read;
                addr_q <= last_addr ? '0 : addr_q + 1'b1;
                if (last_addr && !final_read) ch_q <= lowest_src(above);
            end
        end
    end

    sample_skid_fifo #(.W(FW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (infl_q),
        .wr_data ({mux_y, wr_tag}),
        .rd_en   (pop),
        .rd_data (fifo_out),
        .valid   (m_valid),
        .count   (count)
    );
endmodule

// File: tb/tb_trace_read_seq.sv
// tb_trace_read_seq: scoreboard bench for trace_read_seq with BRAM model
module tb_trace_read_seq;
    localparam int WIDTH = 8, ADDR_W = 10, DEPTH = 4;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] ch;
        logic [9:0] idx;
        logic       last;
    } beat_t;

    logic              clk = 0, rst_n = 0, start = 0, m_ready = 1;
    logic [4:0]        ch_mask = 0;
    logic              busy, done, bram_en, m_last, m_valid;
    logic [ADDR_W-1:0] bram_addr, m_idx;
    logic [2:0]        sel, m_ch;
    logic [WIDTH-1:0]  mux_y, m_data;
    logic [7:0]        bram_q [5];

    int    tests = 0, fails = 0, cyc = 0;
    int    beats, lasts, done_cnt, done_cyc, first_v, last_cyc;
    bit    en_seen, busy_seen, rnd_ready = 0, en_d = 0, hold_v = 0;
    logic [4:0] mask_cur = 0;
    logic [7:0] salt_cur = 0;
    beat_t held;
    beat_t q[$];

    trace_read_seq #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ch_mask(ch_mask),
        .busy(busy), .done(done), .bram_en(bram_en), .bram_addr(bram_addr),
        .sel(sel), .mux_y(mux_y), .m_data(m_data), .m_ch(m_ch), .m_idx(m_idx),
        .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // five BRAMs with one-cycle read latency feeding the 5:1 mux
    always @(posedge clk)
        if (bram_en)
            for (int k = 0; k < 5; k++) bram_q[k] <= 8'(16 * k + int'(bram_addr)) ^ salt_cur;
    assign mux_y = (sel < 3'd5) ? bram_q[sel] : 8'h00;

    always @(posedge clk) begin
        #1;
        m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: pops the scoreboard on every transferred beat
    always @(negedge clk) begin
        beat_t cur;
        cur = '{m_data, m_ch, m_idx, m_last};
        if (!rst_n) begin
            en_d   = 0;
            hold_v = 0;
        end else begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bram_en) en_seen = 1;
            if (busy) busy_seen = 1;
            if (m_valid && first_v < 0) first_v = cyc;
            if (en_d) check("sel_enabled", int'(sel < 3'd5 && mask_cur[sel]), 1);
            if (hold_v) check("stable", int'(m_valid && cur == held), 1);
            if (m_valid && m_ready) begin
                if (q.size() == 0) check("unexpected_beat", 1, 0);
                else begin
                    beat_t e;
                    e = q.pop_front();
                    tests++;
                    if (cur !== e) begin
                        fails++;
                        $display("FAIL beat: got d=%h ch=%0d idx=%0d last=%0b expected d=%h ch=%0d idx=%0d last=%0b",
                                 cur.d, cur.ch, cur.idx, cur.last, e.d, e.ch, e.idx, e.last);
                    end
                end
                beats++;
                if (m_last) lasts++;
                last_cyc = cyc;
            end
            hold_v = m_valid && !m_ready;
            held   = cur;
            en_d   = bram_en;
        end
    end

    task automatic push_frame(input logic [4:0] mask, input logic [7:0] salt);
        int hi;
        hi = -1;
        for (int k = 0; k < 5; k++) if (mask[k]) hi = k;
        for (int k = 0; k < 5; k++)
            if (mask[k])
                for (int a = 0; a < DEPTH; a++)
                    q.push_back('{8'(16 * k + a) ^ salt, 3'(k), 10'(a), k == hi && a == DEPTH - 1});
    endtask

    task automatic begin_frame(input logic [4:0] mask, input bit rnd, input logic [7:0] salt, output int t0);
        rnd_ready = rnd;
        salt_cur  = salt;
        mask_cur  = mask;
        push_frame(mask, salt);
        beats = 0; lasts = 0; done_cnt = 0; first_v = -1; last_cyc = -1;
        en_seen = 0; busy_seen = 0;
        @(posedge clk); #1;
        start = 1; ch_mask = mask; t0 = cyc;
        @(posedge clk); #1;
        start = 0; ch_mask = 5'($urandom);
    endtask

    task automatic run_frame(input logic [4:0] mask, input bit rnd, input logic [7:0] salt, input bit restart);
        int t0, n, nd;
        bit ok;
        begin_frame(mask, rnd, salt, t0);
        nd = $countones(mask) * DEPTH;
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk); #1;
            start = restart && i == 5;
            if (start) ch_mask = 5'b11111;
            ok = done_cnt > 0;
        end
        start = 0;
        if (!ok) check("done_timeout", 0, 1);
        repeat (4) @(negedge clk);
        #1;
        n = $countones(mask);
        check("done_count", done_cnt, 1);
        check("beat_count", beats, nd);
        check("last_count", lasts, n > 0 ? 1 : 0);
        check("queue_empty", q.size(), 0);
        if (!rnd) check("done_cycle", done_cyc - t0, n > 0 ? 3 + nd : 1);
        if (!rnd && n > 0) begin
            check("first_valid", first_v - t0, 3);
            check("last_beat", last_cyc - t0, 2 + nd);
        end
        if (n == 0) begin
            check("no_bram_en", int'(en_seen), 0);
            check("no_busy", int'(busy_seen), 0);
        end
    endtask

    initial begin
        int t0;
        bit ok;
        #1;
        check("reset_outputs", int'({busy, done, bram_en, bram_addr, sel, m_valid, m_data, m_ch, m_idx, m_last}), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        run_frame(5'b11111, 0, 8'h00, 0);
        run_frame(5'b10010, 0, 8'h00, 0);
        run_frame(5'b11111, 1, 8'h00, 0);
        run_frame(5'b00000, 0, 8'h00, 0);
        run_frame(5'b01101, 1, 8'h3C, 1);
        run_frame(5'b00001, 0, 8'hA5, 1);
        begin_frame(5'b11111, 0, 8'h11, t0);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk); #1;
            ok = beats >= 7;
        end
        if (!ok) check("beat7_timeout", 0, 1);
        rst_n = 0;
        #1;
        check("async_reset_outputs", int'({busy, done, bram_en, bram_addr, sel, m_valid, m_data, m_ch, m_idx, m_last}), 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        check("no_done_on_reset", done_cnt, 0);
        run_frame(5'b11111, 0, 8'h5A, 0);
        for (int i = 0; i < 4; i++)
            run_frame(5'($urandom_range(1, 31)), 1, 8'($urandom), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
